// File: rtl/halt_detector_if.sv
// rtl/halt_detector_if.sv - commit, store-buffer and halt-status signals between the core and the halt detector
interface halt_detector_if;
  logic        commit0_valid;
  logic        commit0_isHalt;
  logic        commit1_valid;
  logic        commit1_isHalt;
  logic        sb_empty;
  logic        stop_fetch;
  logic        isHalt;
  logic [1:0]  halt_cause;
  logic [31:0] instret;

  modport master (
    output commit0_valid, commit0_isHalt, commit1_valid, commit1_isHalt, sb_empty,
    input  stop_fetch, isHalt, halt_cause, instret
  );

  modport slave (
    input  commit0_valid, commit0_isHalt, commit1_valid, commit1_isHalt, sb_empty,
    output stop_fetch, isHalt, halt_cause, instret
  );
endinterface

// File: rtl/halt_detector.sv
// rtl/halt_detector.sv - retires commits, detects halt/timeout, waits for store-buffer drain, then halts
module halt_detector #(
  parameter int unsigned MAX_CYCLES = 500000,
  parameter int unsigned DRAIN_MAX  = 64
) (
  input logic          clk,
  input logic          reset,
  halt_detector_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_CYCLE = 2'd2;
  localparam logic [1:0] CAUSE_DRAIN = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] drain_q, drain_d;
  logic [1:0]  cause_q, cause_d;
  logic        stop_q, stop_d;
  logic        is_halt_q, is_halt_d;

  logic        commit_halt;
  logic [1:0]  commit_cnt;

  // Slot 1 only counts behind a valid, non-halting slot 0.
  always_comb begin
    commit_cnt  = 2'd0;
    commit_halt = 1'b0;
    if (bus.commit0_valid) begin
      if (bus.commit0_isHalt) begin
        commit_cnt  = 2'd1;
        commit_halt = 1'b1;
      end else if (bus.commit1_valid) begin
        commit_cnt  = 2'd2;
        commit_halt = bus.commit1_isHalt;
      end else begin
        commit_cnt  = 2'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    cycle_d   = cycle_q;
    drain_d   = drain_q;
    cause_d   = cause_q;
    stop_d    = stop_q;
    is_halt_d = is_halt_q;
    case (state_q)
      RUN: begin
        cycle_d   = cycle_q + 32'd1;
        instret_d = instret_q + {30'd0, commit_cnt};
        if (commit_halt) begin
          state_d = DRAIN;
          drain_d = 32'd0;
          cause_d = CAUSE_HALT;
          stop_d  = 1'b1;
        end else if (cycle_q == MAX_CYCLES) begin
          state_d   = HALTED;
          cause_d   = CAUSE_CYCLE;
          stop_d    = 1'b1;
          is_halt_d = 1'b1;
        end
      end
      DRAIN: begin
        cycle_d = cycle_q + 32'd1;
        drain_d = drain_q + 32'd1;
        // The drain counter reaches DRAIN_MAX on the increment at the end of this cycle.
        if (bus.sb_empty) begin
          state_d   = HALTED;
          is_halt_d = 1'b1;
        end else if (drain_q == DRAIN_MAX - 32'd1) begin
          state_d   = HALTED;
          cause_d   = CAUSE_DRAIN;
          is_halt_d = 1'b1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      instret_q <= 32'd0;
      cycle_q   <= 32'd0;
      drain_q   <= 32'd0;
      cause_q   <= CAUSE_NONE;
      stop_q    <= 1'b0;
      is_halt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      cycle_q   <= cycle_d;
      drain_q   <= drain_d;
      cause_q   <= cause_d;
      stop_q    <= stop_d;
      is_halt_q <= is_halt_d;
    end
  end

  assign bus.stop_fetch = stop_q;
  assign bus.isHalt     = is_halt_q;
  assign bus.halt_cause = cause_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_halt_detector.sv
// tb/tb_halt_detector.sv - directed-vector bench for halt_detector
module tb_halt_detector;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  halt_detector_if bus_a ();
  halt_detector_if bus_b ();

  halt_detector #(.MAX_CYCLES(20), .DRAIN_MAX(64)) u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  halt_detector #(.MAX_CYCLES(1000), .DRAIN_MAX(4)) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic c0v, input logic c0h, input logic c1v, input logic c1h, input logic sb);
    bus_a.commit0_valid  = c0v;
    bus_a.commit0_isHalt = c0h;
    bus_a.commit1_valid  = c1v;
    bus_a.commit1_isHalt = c1h;
    bus_a.sb_empty       = sb;
  endtask

  task automatic drive_b(input logic c0v, input logic c0h, input logic c1v, input logic c1h, input logic sb);
    bus_b.commit0_valid  = c0v;
    bus_b.commit0_isHalt = c0h;
    bus_b.commit1_valid  = c1v;
    bus_b.commit1_isHalt = c1h;
    bus_b.sb_empty       = sb;
  endtask

  task automatic expect_a(input string tag, input logic h, input logic s, input logic [1:0] c, input logic [31:0] n);
    check({tag, ".isHalt"},     32'(bus_a.isHalt),     32'(h));
    check({tag, ".stop_fetch"}, 32'(bus_a.stop_fetch), 32'(s));
    check({tag, ".halt_cause"}, 32'(bus_a.halt_cause), 32'(c));
    check({tag, ".instret"},    bus_a.instret,         n);
  endtask

  task automatic expect_b(input string tag, input logic h, input logic s, input logic [1:0] c, input logic [31:0] n);
    check({tag, ".isHalt"},     32'(bus_b.isHalt),     32'(h));
    check({tag, ".stop_fetch"}, 32'(bus_b.stop_fetch), 32'(s));
    check({tag, ".halt_cause"}, 32'(bus_b.halt_cause), 32'(c));
    check({tag, ".instret"},    bus_b.instret,         n);
  endtask

  task automatic reset_a();
    drive_a(0, 0, 0, 0, 0);
    rst_a = 1'b1;
    #1;
    expect_a("rst_a_async", 0, 0, 0, 0);
    step(2);
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    drive_b(0, 0, 0, 0, 0);
    rst_b = 1'b1;
    step(2);
    rst_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    step(2);
    expect_a("reset_a", 0, 0, 0, 0);
    expect_b("reset_b", 0, 0, 0, 0);
    rst_a = 1'b0;

    // 10 dual-commit cycles, then slot-0 halt with slot 1 valid.
    drive_a(1, 0, 1, 0, 1);
    step(10);
    expect_a("t1_dual", 0, 0, 0, 20);
    drive_a(1, 1, 1, 0, 1);
    step(1);
    expect_a("t1_commit", 0, 1, 1, 21);
    drive_a(1, 1, 1, 1, 1);
    step(1);
    expect_a("t1_halted", 1, 1, 1, 21);
    step(2);
    expect_a("t1_sticky", 1, 1, 1, 21);

    // Slot-1 halt, store buffer busy for 5 drain cycles.
    reset_a();
    drive_a(1, 0, 1, 1, 0);
    step(1);
    expect_a("t2_commit", 0, 1, 1, 2);
    drive_a(1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      expect_a("t2_drain", 0, 1, 1, 2);
    end
    bus_a.sb_empty = 1'b1;
    #1;
    expect_a("t2_sb_seen", 0, 1, 1, 2);
    step(1);
    expect_a("t2_halted", 1, 1, 1, 2);

    // Cycle timeout; lone slot-1 commit is ignored.
    reset_a();
    drive_a(0, 0, 1, 1, 0);
    step(1);
    expect_a("t3_slot1_only", 0, 0, 0, 0);
    drive_a(1, 0, 0, 0, 0);
    step(19);
    expect_a("t3_at_max", 0, 0, 0, 19);
    step(1);
    expect_a("t3_timeout", 1, 1, 2, 20);
    drive_a(1, 1, 1, 0, 1);
    step(3);
    expect_a("t3_frozen", 1, 1, 2, 20);

    // Halt commit on the same cycle the counter equals MAX_CYCLES.
    reset_a();
    step(20);
    expect_a("t4_idle", 0, 0, 0, 0);
    drive_a(1, 1, 0, 0, 0);
    step(1);
    expect_a("t4_priority", 0, 1, 1, 1);
    drive_a(0, 0, 0, 0, 0);
    step(3);
    expect_a("t4_drain_no_to", 0, 1, 1, 1);
    bus_a.sb_empty = 1'b1;
    step(1);
    expect_a("t4_halted", 1, 1, 1, 1);

    // Reset pulsed between edges while draining.
    reset_a();
    drive_a(1, 0, 1, 1, 0);
    step(1);
    expect_a("t5_commit", 0, 1, 1, 2);
    drive_a(0, 0, 0, 0, 0);
    step(1);
    #2;
    rst_a = 1'b1;
    #1;
    expect_a("t5_async_clear", 0, 0, 0, 0);
    step(1);
    rst_a = 1'b0;
    drive_a(1, 0, 1, 0, 0);
    step(3);
    expect_a("t5_recount", 0, 0, 0, 6);

    // Drain timeout with DRAIN_MAX=4.
    reset_b();
    drive_b(1, 1, 0, 0, 0);
    step(1);
    expect_b("t6_commit", 0, 1, 1, 1);
    drive_b(0, 0, 0, 0, 0);
    step(3);
    expect_b("t6_drain3", 0, 1, 1, 1);
    step(1);
    expect_b("t6_drain_to", 1, 1, 3, 1);
    bus_b.sb_empty = 1'b1;
    step(2);
    expect_b("t6_sticky", 1, 1, 3, 1);

    // sb_empty wins over drain timeout in the same cycle.
    reset_b();
    drive_b(1, 1, 0, 0, 0);
    step(1);
    drive_b(0, 0, 0, 0, 0);
    step(3);
    expect_b("t7_drain3", 0, 1, 1, 1);
    bus_b.sb_empty = 1'b1;
    step(1);
    expect_b("t7_sb_wins", 1, 1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
